regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 70 +++++++
 tb/tb_regfile_sb.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: byte-enabled register file with link redirect, write-to-read bypass
// and a per-register pending-write scoreboard.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int LINK_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  wr_link,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  output logic                  stall,
  input  logic                  busy_set,
  input  logic [ADDR_W-1:0]     busy_addr,
  output logic [ADDR_W:0]       busy_cnt,
  output logic [DATA_W-1:0]     reg_v0
);
  localparam int NR = 2**ADDR_W;
  localparam int NB = DATA_W/8;
  logic [DATA_W-1:0] regs [NR];
  logic [NR-1:0]     busy, busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic [ADDR_W-1:0] ewa;
  logic [DATA_W-1:0] merged;
  logic              clr, we;
  assign ewa = wr_link ? ADDR_W'(LINK_REG) : wr_addr;
  // Gating with reset keeps bypass/busy-forcing from leaking through while held in reset.
  assign clr = wr_en && reset;
  assign we  = clr && ewa != '0;
  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign merged[b*8 +: 8] = wr_be[b] ? wr_data[b*8 +: 8] : regs[ewa][b*8 +: 8];
  end
  always_comb begin
    busy_nxt = busy;
    if (wr_en) busy_nxt[ewa] = 1'b0;
    if (busy_set) busy_nxt[busy_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int i = 0; i < NR; i++) cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NR; i++) regs[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (we) regs[ewa] <= merged;
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;
    assign ra  = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit = BYPASS != 0 && clr && ewa == ra;
    assign rd_data[k*DATA_W +: DATA_W] = ra == '0 ? '0 : hit ? merged : regs[ra];
    assign rd_busy[k] = busy[ra] && !hit;
  end
  assign stall  = |rd_busy;
  assign reg_v0 = regs[2];
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized checks of regfile_sb against a behavioural model.
module tb_regfile_sb;
  logic        clk = 1'b0, reset, wr_en, wr_link, busy_set, stall;
  logic [4:0]  wr_addr, busy_addr;
  logic [31:0] wr_data, reg_v0;
  logic [3:0]  wr_be;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [5:0]  busy_cnt;
  logic [31:0] mreg [32];
  bit          mbusy [32];
  int          checks = 0, failures = 0;

  regfile_sb dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .wr_link(wr_link), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .stall(stall), .busy_set(busy_set), .busy_addr(busy_addr),
    .busy_cnt(busy_cnt), .reg_v0(reg_v0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [4:0] eff_addr();
    return wr_link ? 5'd31 : wr_addr;
  endfunction

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(mbusy[i]);
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mreg[i] = '0;
      mbusy[i] = 1'b0;
    end
  endtask

  task automatic drive(input logic we, input logic lk, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic bs, input logic [4:0] ba,
                       input logic [4:0] r0, input logic [4:0] r1);
    wr_en = we; wr_link = lk; wr_addr = wa; wr_data = wd; wr_be = be;
    busy_set = bs; busy_addr = ba; rd_addr = {r1, r0};
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    drive(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, r0, r1);
    #1;
  endtask

  task automatic check_model();
    logic [4:0] ra;
    logic [31:0] ed;
    logic eb, any = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ra = k == 0 ? rd_addr[4:0] : rd_addr[9:5];
      ed = ra == 0 ? 32'd0 : (wr_en && eff_addr() == ra) ? merge(mreg[ra], wr_data, wr_be) : mreg[ra];
      eb = mbusy[ra] && !(wr_en && eff_addr() == ra);
      any |= eb;
      chk($sformatf("rd_data[%0d] a=%0d", k, ra), 64'(rd_data[k*32 +: 32]), 64'(ed));
      chk($sformatf("rd_busy[%0d] a=%0d", k, ra), 64'(rd_busy[k]), 64'(eb));
    end
    chk("stall", 64'(stall), 64'(any));
    chk("busy_cnt", 64'(busy_cnt), 64'(model_cnt()));
    chk("reg_v0", 64'(reg_v0), 64'(mreg[2]));
  endtask

  task automatic tick();
    logic [4:0] a = eff_addr();
    @(posedge clk);
    if (wr_en && a != 0) mreg[a] = merge(mreg[a], wr_data, wr_be);
    if (wr_en) mbusy[a] = 1'b0;
    if (busy_set && busy_addr != 0) mbusy[busy_addr] = 1'b1;
    @(negedge clk);
  endtask

  task automatic step(input logic we, input logic lk, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [3:0] be, input logic bs, input logic [4:0] ba,
                      input logic [4:0] r0, input logic [4:0] r1);
    drive(we, lk, wa, wd, be, bs, ba, r0, r1);
    #1;
    check_model();
    tick();
  endtask

  initial begin
    reset = 1'b0;
    model_clear();
    drive(1'b1, 1'b0, 5'd2, 32'hFFFF_FFFF, 4'hF, 1'b1, 5'd2, 5'd2, 5'd2);
    #2;
    chk("reset rd_data", rd_data, 64'd0);
    chk("reset rd_busy", 64'(rd_busy), 64'd0);
    chk("reset busy_cnt", 64'(busy_cnt), 64'd0);
    chk("reset reg_v0", 64'(reg_v0), 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("write in reset ignored", 64'(reg_v0), 64'd0);
    reset = 1'b1;
    idle(5'd2, 5'd0);
    check_model();

    step(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 5'd5, 5'd0);
    step(1'b1, 1'b0, 5'd5, 32'h00001200, 4'h2, 1'b0, 5'd0, 5'd5, 5'd5);
    idle(5'd5, 5'd0);
    chk("r5 byte merge", 64'(rd_data[31:0]), 64'hDEAD12EF);

    drive(1'b1, 1'b1, 5'd0, 32'h00400008, 4'hF, 1'b0, 5'd0, 5'd31, 5'd0);
    #1;
    chk("link bypass r31", 64'(rd_data[31:0]), 64'h00400008);
    chk("link r0 zero", 64'(rd_data[63:32]), 64'd0);
    check_model();
    tick();
    idle(5'd31, 5'd0);
    chk("link r31 stored", 64'(rd_data[31:0]), 64'h00400008);

    step(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd7, 5'd7, 5'd0);
    idle(5'd7, 5'd1);
    chk("r7 rd_busy", 64'(rd_busy), 64'd1);
    chk("r7 stall", 64'(stall), 64'd1);
    chk("r7 busy_cnt", 64'(busy_cnt), 64'd1);
    drive(1'b1, 1'b0, 5'd7, 32'h1234_5678, 4'hF, 1'b0, 5'd0, 5'd7, 5'd1);
    #1;
    chk("r7 busy bypassed", 64'(rd_busy), 64'd0);
    chk("r7 stall bypassed", 64'(stall), 64'd0);
    tick();
    idle(5'd7, 5'd0);
    chk("r7 busy_cnt cleared", 64'(busy_cnt), 64'd0);

    step(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 4'hF, 1'b1, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    chk("r0 reads zero", rd_data, 64'd0);
    chk("r0 never busy", 64'(busy_cnt), 64'd0);

    step(1'b1, 1'b0, 5'd9, 32'hCAFE_F00D, 4'hF, 1'b1, 5'd9, 5'd9, 5'd0);
    idle(5'd9, 5'd0);
    chk("r9 data", 64'(rd_data[31:0]), 64'hCAFEF00D);
    chk("r9 busy kept", 64'(rd_busy[0]), 64'd1);
    chk("r9 busy_cnt", 64'(busy_cnt), 64'd1);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0), 5'($urandom),
           32'($urandom), 4'($urandom), 1'($urandom_range(0, 2) == 0), 5'($urandom),
           5'($urandom), 5'($urandom));

    step(1'b1, 1'b0, 5'd2, 32'h0000_0055, 4'hF, 1'b1, 5'd3, 5'd2, 5'd3);
    step(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd4, 5'd3, 5'd4);
    step(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd6, 5'd3, 5'd6);
    drive(1'b1, 1'b0, 5'd2, 32'h0000_0077, 4'hF, 1'b1, 5'd8, 5'd2, 5'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("async reset reg_v0", 64'(reg_v0), 64'd0);
    chk("async reset busy_cnt", 64'(busy_cnt), 64'd0);
    chk("async reset stall", 64'(stall), 64'd0);
    chk("async reset rd_data", rd_data, 64'd0);
    model_clear();
    @(negedge clk);
    chk("held reset reg_v0", 64'(reg_v0), 64'd0);
    chk("held reset busy_cnt", 64'(busy_cnt), 64'd0);
    reset = 1'b1;
    step(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 5'd2, 5'd8);
    step(1'b1, 1'b0, 5'd2, 32'hA5A5_A5A5, 4'h5, 1'b1, 5'd2, 5'd2, 5'd8);
    idle(5'd2, 5'd0);
    check_model();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
